// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state and fail-code types for the run controller
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_ERROR   = 2'd2
    } fail_code_t;

endpackage

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - holds the test module in reset, times its run, and latches the verdict
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 100,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             dut_done,
    input  logic             dut_error,
    input  logic             restart,
    output logic             dut_reset_l,
    output logic [CNT_W-1:0] cycle_count,
    output logic             finished,
    output logic             pass,
    output logic [1:0]       fail_code
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            dut_reset_l <= 1'b0;
            cycle_count <= '0;
            finished    <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
        end else begin
            case (state)
                ST_HOLD: begin
                    // The hold counter parks at its terminal value once released.
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_RUN;
                        dut_reset_l <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (dut_error) begin
                        state       <= ST_FAIL;
                        dut_reset_l <= 1'b0;
                        finished    <= 1'b1;
                        fail_code   <= FC_ERROR;
                    end else if (dut_done) begin
                        state       <= ST_PASS;
                        dut_reset_l <= 1'b0;
                        finished    <= 1'b1;
                        pass        <= 1'b1;
                    end else if (cycle_count == RUN_LAST) begin
                        state       <= ST_FAIL;
                        dut_reset_l <= 1'b0;
                        finished    <= 1'b1;
                        fail_code   <= FC_TIMEOUT;
                    end else begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (restart) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= '0;
                        cycle_count <= '0;
                        finished    <= 1'b0;
                        pass        <= 1'b0;
                        fail_code   <= FC_NONE;
                    end
                end
                default: state <= ST_HOLD;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset_l) begin
            assert (!pass || finished);
            assert ((fail_code == FC_NONE) || (finished && !pass));
            assert (cycle_count < CNT_W'(TIMEOUT));
        end
    end

    cover property (@(posedge clk) disable iff (!reset_l) state == ST_PASS);
    cover property (@(posedge clk) disable iff (!reset_l) state == ST_FAIL);

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed scoreboard bench for run_ctrl
module tb_run_ctrl;

    typedef struct {
        logic        exp_pass;
        logic [1:0]  exp_code;
        logic [31:0] exp_count;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        dut_done = 1'b0;
    logic        dut_error = 1'b0;
    logic        restart = 1'b0;
    logic        dut_reset_l;
    logic [31:0] cycle_count;
    logic        finished;
    logic        pass;
    logic [1:0]  fail_code;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    run_ctrl #(.RESET_CYCLES(4), .TIMEOUT(100), .CNT_W(32)) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .dut_done    (dut_done),
        .dut_error   (dut_error),
        .restart     (restart),
        .dut_reset_l (dut_reset_l),
        .cycle_count (cycle_count),
        .finished    (finished),
        .pass        (pass),
        .fail_code   (fail_code)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dut_reset_l"}, 32'(dut_reset_l), 32'd0);
        check({tag, "_cycle_count"}, cycle_count, 32'd0);
        check({tag, "_finished"}, 32'(finished), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fail_code"}, 32'(fail_code), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset_l = 1'b0;
        #2;
        check_idle(tag);
        tick();
        reset_l = 1'b1;
    endtask

    task automatic wait_release(input string tag);
        logic seen = 1'b0;
        int   edges = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (dut_reset_l === 1'b1) begin
                seen  = 1'b1;
                edges = i;
                break;
            end
        end
        check({tag, "_release_seen"}, 32'(seen), 32'd1);
        check({tag, "_release_edges"}, 32'(edges), 32'd4);
        check({tag, "_run_start_count"}, cycle_count, 32'd0);
    endtask

    task automatic run_to(input string tag, input logic [31:0] target);
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cycle_count === target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_reached_count"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_finish(input string tag);
        logic seen = 1'b0;
        int   lat = 0;
        exp_t e;
        for (int i = 1; i <= 5; i++) begin
            tick();
            dut_done  = 1'b0;
            dut_error = 1'b0;
            if (finished === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        check({tag, "_finished_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pass"}, 32'(pass), 32'(e.exp_pass));
            check({tag, "_fail_code"}, 32'(fail_code), 32'(e.exp_code));
            check({tag, "_cycle_count"}, cycle_count, e.exp_count);
            check({tag, "_dut_reset_l"}, 32'(dut_reset_l), 32'd0);
        end else begin
            check({tag, "_scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    initial begin
        // done at count 3
        apply_reset("rst0");
        wait_release("s1");
        run_to("s1", 32'd3);
        dut_done = 1'b1;
        sb.push_back('{1'b1, 2'd0, 32'd3});
        wait_finish("s1_done");
        tick();
        check("s1_frozen_count", cycle_count, 32'd3);

        // timeout
        apply_reset("rst1");
        wait_release("s2");
        run_to("s2", 32'd99);
        sb.push_back('{1'b0, 2'd1, 32'd99});
        wait_finish("s2_timeout");

        // done and error together: error wins
        apply_reset("rst2");
        wait_release("s3");
        run_to("s3", 32'd5);
        dut_done  = 1'b1;
        dut_error = 1'b1;
        sb.push_back('{1'b0, 2'd2, 32'd5});
        wait_finish("s3_both");

        // done on the last run cycle beats timeout
        apply_reset("rst3");
        wait_release("s4");
        run_to("s4", 32'd99);
        dut_done = 1'b1;
        sb.push_back('{1'b1, 2'd0, 32'd99});
        wait_finish("s4_done_last");

        // asynchronous reset mid-run
        apply_reset("rst4");
        wait_release("s5");
        run_to("s5", 32'd40);
        check("s5_running_dut_reset_l", 32'(dut_reset_l), 32'd1);
        #2;
        reset_l = 1'b0;
        #1;
        check_idle("s5_async");
        tick();
        reset_l = 1'b1;
        wait_release("s5_after");

        // restart ignored in RUN, honoured in PASS
        run_to("s6", 32'd10);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("s6_run_restart_finished", 32'(finished), 32'd0);
        check("s6_run_restart_dut_reset_l", 32'(dut_reset_l), 32'd1);
        check("s6_run_restart_count", cycle_count, 32'd11);
        run_to("s6", 32'd12);
        dut_done = 1'b1;
        sb.push_back('{1'b1, 2'd0, 32'd12});
        wait_finish("s6_done");
        dut_error = 1'b1;
        tick();
        dut_error = 1'b0;
        check("s6_pass_ignores_error_pass", 32'(pass), 32'd1);
        check("s6_pass_ignores_error_code", 32'(fail_code), 32'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle("s6_restart");
        wait_release("s6_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
